// File: rtl/sn_dispatch_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sn_dispatch_ctrl_if : SN request ports and chunk-dispatch bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface sn_dispatch_ctrl_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int WL_LEN_BITS = 8,
  parameter int NUM_CH      = 4,
  parameter int CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]             SN_next_op;
  logic [NUM_CH*ADDR_WIDTH-1:0]  SN_next_addr;
  logic [NUM_CH*WL_LEN_BITS-1:0] SN_next_len;
  logic [NUM_CH-1:0]             SN_clr_next;
  logic [NUM_CH-1:0]             SN_req_done;
  logic                          start_dispatch;
  logic                          done_exe;
  logic [ADDR_WIDTH-1:0]         WL_addr;
  logic [WL_LEN_BITS-1:0]        WL_len;
  logic [CH_BITS-1:0]            WL_ch;
  logic                          busy;

  modport master (
    input  SN_next_op, SN_next_addr, SN_next_len, done_exe,
    output SN_clr_next, SN_req_done, start_dispatch, WL_addr, WL_len, WL_ch, busy
  );

  modport slave (
    output SN_next_op, SN_next_addr, SN_next_len, done_exe,
    input  SN_clr_next, SN_req_done, start_dispatch, WL_addr, WL_len, WL_ch, busy
  );
endinterface
`default_nettype wire

// File: rtl/sn_dispatch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sn_dispatch_ctrl : round-robin SN request arbiter with chunked dispatch
// Rev 1.0
// ----------------------------------------------------------------------------
module sn_dispatch_ctrl #(
  parameter int ADDR_WIDTH      = 64,
  parameter int WL_LEN_BITS     = 8,
  parameter int NUM_CH          = 4,
  parameter int MAX_CHUNK       = 2**WL_LEN_BITS - 1,
  parameter int ELEM_BYTES_LOG2 = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sn_dispatch_ctrl_if.master bus
);
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW      = CH_BITS + 1;
  localparam logic [WL_LEN_BITS-1:0] c_max_chunk = WL_LEN_BITS'(MAX_CHUNK);
  localparam logic [CH_BITS-1:0]     c_last_ch   = CH_BITS'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_WAIT     = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CH_BITS-1:0]     r_rr_ptr;
  logic [CH_BITS-1:0]     r_cur_ch;
  logic [ADDR_WIDTH-1:0]  r_cur_addr;
  logic [WL_LEN_BITS-1:0] r_remaining;
  logic [NUM_CH-1:0]      r_clr_next;
  logic [NUM_CH-1:0]      r_req_done;
  logic                   r_start;
  logic                   r_busy;
  logic [ADDR_WIDTH-1:0]  r_wl_addr;
  logic [WL_LEN_BITS-1:0] r_wl_len;
  logic [CH_BITS-1:0]     r_wl_ch;

  logic                   w_grant_vld;
  logic [CH_BITS-1:0]     w_grant;
  logic [IW-1:0]          w_idx;
  logic [ADDR_WIDTH-1:0]  w_grant_addr;
  logic [WL_LEN_BITS-1:0] w_grant_len;
  logic [WL_LEN_BITS-1:0] w_chunk;
  logic [WL_LEN_BITS-1:0] w_rem_after;
  logic [ADDR_WIDTH-1:0]  w_addr_adv;

  // First pending channel at or above rr_ptr, wrapping past NUM_CH-1.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, r_rr_ptr} + IW'(k);
      if (w_idx >= IW'(NUM_CH)) w_idx = w_idx - IW'(NUM_CH);
      if (!w_grant_vld && bus.SN_next_op[w_idx[CH_BITS-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx[CH_BITS-1:0];
      end
    end
  end

  assign w_grant_addr = bus.SN_next_addr[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_grant_len  = bus.SN_next_len[w_grant*WL_LEN_BITS +: WL_LEN_BITS];
  assign w_chunk      = (r_remaining > c_max_chunk) ? c_max_chunk : r_remaining;
  assign w_rem_after  = r_remaining - r_wl_len;
  assign w_addr_adv   = ADDR_WIDTH'(r_wl_len) << ELEM_BYTES_LOG2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_grant_vld)
                    w_state_nxt = (w_grant_len == '0) ? S_COMPLETE : S_DISPATCH;
      S_DISPATCH: w_state_nxt = S_WAIT;
      S_WAIT:     if (bus.done_exe)
                    w_state_nxt = (w_rem_after == '0) ? S_COMPLETE : S_DISPATCH;
      S_COMPLETE: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_cur_ch    <= '0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_clr_next  <= '0;
      r_req_done  <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_wl_addr   <= '0;
      r_wl_len    <= '0;
      r_wl_ch     <= '0;
    end else begin
      r_clr_next <= '0;
      r_req_done <= '0;
      r_start    <= 1'b0;
      r_busy     <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: if (w_grant_vld) begin
          r_cur_addr  <= w_grant_addr;
          r_remaining <= w_grant_len;
          r_cur_ch    <= w_grant;
          r_clr_next  <= NUM_CH'(1) << w_grant;
          r_rr_ptr    <= (w_grant == c_last_ch) ? '0 : w_grant + 1'b1;
        end
        S_DISPATCH: begin
          r_start   <= 1'b1;
          r_wl_addr <= r_cur_addr;
          r_wl_len  <= w_chunk;
          r_wl_ch   <= r_cur_ch;
        end
        // Address wraps modulo 2**ADDR_WIDTH by truncation.
        S_WAIT: if (bus.done_exe) begin
          r_remaining <= w_rem_after;
          r_cur_addr  <= r_cur_addr + w_addr_adv;
        end
        S_COMPLETE: r_req_done <= NUM_CH'(1) << r_cur_ch;
        default: ;
      endcase
    end
  end

  assign bus.SN_clr_next    = r_clr_next;
  assign bus.SN_req_done    = r_req_done;
  assign bus.start_dispatch = r_start;
  assign bus.WL_addr        = r_wl_addr;
  assign bus.WL_len         = r_wl_len;
  assign bus.WL_ch          = r_wl_ch;
  assign bus.busy           = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_sn_dispatch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sn_dispatch_ctrl : directed + randomized bench against a transaction model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sn_dispatch_ctrl;
  localparam int AW = 64;
  localparam int LB = 8;
  localparam int NC = 4;
  localparam int MC = 4;
  localparam int EB = 3;
  localparam int CB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sn_dispatch_ctrl_if #(.ADDR_WIDTH(AW), .WL_LEN_BITS(LB), .NUM_CH(NC), .CH_BITS(CB)) bus ();

  sn_dispatch_ctrl #(
    .ADDR_WIDTH(AW), .WL_LEN_BITS(LB), .NUM_CH(NC),
    .MAX_CHUNK(MC), .ELEM_BYTES_LOG2(EB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: pending requests and the round-robin start point.
  int          m_rr;
  bit          m_pend[NC];
  logic [63:0] m_addr[NC];
  int          m_len [NC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic [63:0] a, input int l);
    m_pend[c] = 1'b1;
    m_addr[c] = a;
    m_len[c]  = l;
    bus.SN_next_op[c]              = 1'b1;
    bus.SN_next_addr[c*AW +: AW]   = a;
    bus.SN_next_len[c*LB +: LB]    = LB'(l);
  endtask

  task automatic rand_req(input int c);
    logic [63:0] ra;
    int          rl;
    ra = {$urandom(), $urandom()};
    rl = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
    set_req(c, ra, rl);
  endtask

  task automatic maybe_new_reqs();
    for (int c = 0; c < NC; c++)
      if (!m_pend[c] && $urandom_range(0, 3) == 0) rand_req(c);
  endtask

  // Called in an IDLE cycle with the request set already driven; ends in the
  // IDLE cycle that shows SN_req_done.
  task automatic serve(input bit rnd);
    int          g;
    logic [63:0] a;
    int          rem, cl, dly;
    g = -1;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (m_rr + k) % NC;
      if (g < 0 && m_pend[c]) g = c;
    end
    if (g < 0) begin
      n_vec++; n_err++;
      $display("FAIL serve: no pending request to grant");
      return;
    end
    m_rr = (g + 1) % NC;
    a    = m_addr[g];
    rem  = m_len[g];

    tick();
    chk("clr_next", 64'(bus.SN_clr_next), 64'(1 << g));
    chk("busy_grant", 64'(bus.busy), 64'd1);
    bus.SN_next_op[g] = 1'b0;
    m_pend[g] = 1'b0;
    if (rnd) begin
      bus.SN_next_addr[g*AW +: AW] = {$urandom(), $urandom()};
      bus.SN_next_len[g*LB +: LB]  = LB'($urandom());
      bus.done_exe = 1'($urandom_range(0, 1));
      maybe_new_reqs();
    end

    while (rem > 0) begin
      cl = (rem < MC) ? rem : MC;
      tick();
      bus.done_exe = 1'b0;
      chk("start", 64'(bus.start_dispatch), 64'd1);
      chk("wl_addr", bus.WL_addr, a);
      chk("wl_len", 64'(bus.WL_len), 64'(cl));
      chk("wl_ch", 64'(bus.WL_ch), 64'(g));
      chk("req_done_early", 64'(bus.SN_req_done), 64'd0);
      dly = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int i = 0; i < dly; i++) begin
        tick();
        chk("start_wait", 64'(bus.start_dispatch), 64'd0);
        chk("busy_wait", 64'(bus.busy), 64'd1);
      end
      bus.done_exe = 1'b1;
      tick();
      bus.done_exe = 1'b0;
      rem = rem - cl;
      a   = a + (64'(cl) << EB);
      chk("start_after_done", 64'(bus.start_dispatch), 64'd0);
      chk("req_done_gap", 64'(bus.SN_req_done), 64'd0);
      if (rnd) maybe_new_reqs();
    end

    tick();
    bus.done_exe = 1'b0;
    chk("req_done", 64'(bus.SN_req_done), 64'(1 << g));
    chk("busy_end", 64'(bus.busy), 64'd0);
    chk("start_end", 64'(bus.start_dispatch), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clr"},   64'(bus.SN_clr_next), 64'd0);
    chk({tag, "_done"},  64'(bus.SN_req_done), 64'd0);
    chk({tag, "_start"}, 64'(bus.start_dispatch), 64'd0);
    chk({tag, "_addr"},  bus.WL_addr, 64'd0);
    chk({tag, "_len"},   64'(bus.WL_len), 64'd0);
    chk({tag, "_ch"},    64'(bus.WL_ch), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy), 64'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.SN_next_op   = '0;
    bus.SN_next_addr = '0;
    bus.SN_next_len  = '0;
    bus.done_exe     = 1'b0;
    m_rr = 0;
    for (int c = 0; c < NC; c++) begin
      m_pend[c] = 1'b0; m_addr[c] = '0; m_len[c] = 0;
    end

    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single-chunk request.
    set_req(0, 64'h1000, 3);
    serve(1'b0);

    // Split into (0x100,4) (0x120,4) (0x140,2).
    set_req(0, 64'h100, 10);
    serve(1'b0);

    // Zero-length request: acknowledge and complete without dispatch.
    set_req(2, 64'h3000, 0);
    serve(1'b0);

    // Address wrap on the second chunk (leaves rr_ptr at 0).
    set_req(3, 64'hFFFF_FFFF_FFFF_FFE0, 6);
    serve(1'b0);

    // Round robin 0,1,2,3 then wrap to ch0 ahead of ch3.
    for (int c = 0; c < NC; c++) set_req(c, 64'h4000 + 64'(c * 'h100), 1);
    for (int i = 0; i < NC; i++) serve(1'b0);
    set_req(0, 64'h5000, 1);
    set_req(3, 64'h6000, 1);
    serve(1'b0);
    serve(1'b0);

    // Reset in WAIT mid-split.
    set_req(2, 64'h2000, 10);
    tick();
    chk("rst_clr", 64'(bus.SN_clr_next), 64'h4);
    bus.SN_next_op[2] = 1'b0;
    m_pend[2] = 1'b0;
    tick();
    chk("rst_pre_start", 64'(bus.start_dispatch), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst  = 1'b0;
    m_rr = 0;
    bus.done_exe = 1'b1;
    tick();
    bus.done_exe = 1'b0;
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("post_rst_start", 64'(bus.start_dispatch), 64'd0);
    chk("post_rst_done", 64'(bus.SN_req_done), 64'd0);
    set_req(0, 64'h7000, 2);
    set_req(3, 64'h8000, 1);
    serve(1'b0);
    serve(1'b0);

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      bit any;
      any = 1'b0;
      for (int c = 0; c < NC; c++) if (m_pend[c]) any = 1'b1;
      if (!any) begin
        if ($urandom_range(0, 2) == 0) begin
          tick();
          chk("idle_busy", 64'(bus.busy), 64'd0);
        end
        rand_req(int'($urandom_range(0, NC - 1)));
      end
      maybe_new_reqs();
      serve(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
